// File: rtl/mc_pkg.sv
// Shared state, opcode and datapath-select encodings for the multicycle control unit.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       fetch;
    logic       branch;
    logic       pc_write;
    logic       reg_write;
    logic       illegal;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [1:0] imm_src;
  } ctrl_t;

  // Per-state control word; anything a state does not use stays 0.
  function automatic ctrl_t ctrl_for(input state_t s, input logic is_store);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch      = 1'b1;
        c.mem_req    = 1'b1;
        c.adr_src    = 1'b0;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALU;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.imm_src   = IMM_B;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.imm_src   = is_store ? IMM_S : IMM_I;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = RES_MEM;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.adr_src   = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.imm_src   = IMM_I;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        c.branch     = 1'b1;
        c.alu_src_a  = SRCA_RS1;
        c.alu_src_b  = SRCB_RS2;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
      end
      S_JAL: begin
        c.pc_write   = 1'b1;
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALUOUT;
      end
      S_TRAP: begin
        c.illegal = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps the FSM's ALUOp plus instruction function fields onto the ALU control code.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op_b5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  // Only R-type (op bit 5 set) can subtract; addi with imm[10] set stays an add.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V control FSM sharing one req/ready memory, with a retired-instruction
// counter and illegal-opcode trap.
module mc_controller
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W           = 32,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1,
  parameter bit          BNE_EN          = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic [1:0]       result_src,
  output logic [1:0]       imm_src,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t state;
  state_t state_d;
  ctrl_t  ctrl;
  logic   bad_op;
  logic   retire;

  always_comb begin
    bad_op = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL: bad_op = 1'b0;
      OP_BRANCH: bad_op = (funct3 == 3'b001) && !BNE_EN;
      default:   bad_op = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (bad_op) begin
          state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        end else begin
          case (opcode)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_RTYPE:          state_d = S_EXEC_R;
            OP_ITYPE:          state_d = S_EXEC_I;
            OP_BRANCH:         state_d = S_BRANCH;
            OP_JAL:            state_d = S_JAL;
            default:           state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_ALUWB;
      S_EXEC_I:   state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // The control word is registered from the next state so outputs never glitch on state decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
      ctrl  <= ctrl_for(S_FETCH, 1'b0);
    end else begin
      state <= state_d;
      ctrl  <= ctrl_for(state_d, opcode == OP_STORE);
    end
  end

  assign retire = (state == S_MEMWB) ||
                  (state == S_ALUWB) ||
                  (state == S_BRANCH) ||
                  ((state == S_MEMWRITE) && mem_ready) ||
                  ((state == S_DECODE) && bad_op && !TRAP_ON_ILLEGAL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + CNT_W'(1);
    end
  end

  assign mem_req    = ctrl.mem_req;
  assign mem_write  = ctrl.mem_write;
  assign adr_src    = ctrl.adr_src;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign result_src = ctrl.result_src;
  assign imm_src    = ctrl.imm_src;
  assign illegal    = ctrl.illegal;

  // Fetch enables fire only in the cycle memory completes; branches resolve from the live zero flag.
  assign ir_write = ctrl.fetch & mem_ready;
  assign pc_write = ctrl.pc_write |
                    (ctrl.fetch & mem_ready) |
                    (ctrl.branch & (zero ^ funct3[0]));

  mc_alu_decoder u_alu_dec (
    .alu_op      (ctrl.alu_op),
    .funct3      (funct3),
    .op_b5       (opcode[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

endmodule
